// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, operation codes and arbiter state type.
package alu_pkg;

    localparam int ALU_W = 32;

    // Operation codes; 11..15 are unassigned and flagged as errors by the ALU.
    // Shift/immediate conventions: SLL shifts src2 by shamt, SLLV shifts src2 by
    // src1[4:0], LUI places src2[15:0] in the upper half, ORI zero-extends src2[15:0].
    // BNE produces src1 - src2 so the zero flag reports equality.
    typedef enum logic [3:0] {
        ALU_AND  = 4'd0,
        ALU_OR   = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5,
        ALU_BNE  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SLLV = 4'd8,
        ALU_LUI  = 4'd9,
        ALU_ORI  = 4'd10
    } alu_op_e;

    // Output register occupancy of the shared-ALU arbiter.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational ALU shared by both requesters of alu_share_arb.
module alu_share_arb_alu
    import alu_pkg::*;
(
    input  logic [3:0]       ctrl_i,
    input  logic [ALU_W-1:0] src1_i,
    input  logic [ALU_W-1:0] src2_i,
    input  logic [4:0]       shamt_i,
    output logic [ALU_W-1:0] result_o,
    output logic             err_o
);

    // Decode the operation code and compute the result; unknown codes give 0 with err.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result_o = '0;
        err_o    = 1'b0;
        case (ctrl_i)
            ALU_AND:  result_o = src1_i & src2_i;
            ALU_OR:   result_o = src1_i | src2_i;
            ALU_ADD:  result_o = src1_i + src2_i;
            ALU_SUB:  result_o = src1_i - src2_i;
            ALU_SLT:  result_o = {{(ALU_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            ALU_SLTU: result_o = {{(ALU_W-1){1'b0}}, (src1_i < src2_i)};
            ALU_BNE:  result_o = src1_i - src2_i;
            ALU_SLL:  result_o = src2_i << shamt_i;
            ALU_SLLV: result_o = src2_i << src1_i[4:0];
            ALU_LUI:  result_o = {src2_i[15:0], 16'h0000};
            ALU_ORI:  result_o = src1_i | {16'h0000, src2_i[15:0]};
            default:  err_o    = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two requesters share one ALU; a single output register holds the response
// for whichever requester was granted, with round-robin or fixed priority.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic             req1_valid_i,
    output logic             req0_ready_o,
    output logic             req1_ready_o,
    input  logic [ALU_W-1:0] req0_src1_i,
    input  logic [ALU_W-1:0] req0_src2_i,
    input  logic [ALU_W-1:0] req1_src1_i,
    input  logic [ALU_W-1:0] req1_src2_i,
    input  logic [3:0]       req0_ctrl_i,
    input  logic [3:0]       req1_ctrl_i,
    input  logic [4:0]       req0_shamt_i,
    input  logic [4:0]       req1_shamt_i,
    output logic             rsp0_valid_o,
    output logic             rsp1_valid_o,
    input  logic             rsp0_ready_i,
    input  logic             rsp1_ready_i,
    output logic [ALU_W-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_err_o
);

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;   // requester owning the held response
    logic             ptr_q, ptr_d;       // requester granted most recently
    logic [ALU_W-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             owner_rsp_ready;
    logic             can_grant;
    logic             pick1;
    logic             gnt0, gnt1;
    logic [ALU_W-1:0] op_src1, op_src2;
    logic [3:0]       op_ctrl;
    logic [4:0]       op_shamt;
    logic [ALU_W-1:0] alu_result;
    logic             alu_err;

    // Arbitration: choose a requester and decide whether the output register can take it.
    always_comb begin
        owner_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;
        can_grant       = !rst_i && ((state_q == ST_EMPTY) || owner_rsp_ready);
        if (RR_EN != 0) begin
            // On a tie the requester not granted last time wins.
            pick1 = (req0_valid_i && req1_valid_i) ? !ptr_q : req1_valid_i;
        end else begin
            pick1 = req1_valid_i && !req0_valid_i;
        end
        gnt0 = can_grant && req0_valid_i && !pick1;
        gnt1 = can_grant && pick1;
    end

    // Operand mux feeding the shared ALU from the selected requester.
    always_comb begin
        op_src1  = pick1 ? req1_src1_i  : req0_src1_i;
        op_src2  = pick1 ? req1_src2_i  : req0_src2_i;
        op_ctrl  = pick1 ? req1_ctrl_i  : req0_ctrl_i;
        op_shamt = pick1 ? req1_shamt_i : req0_shamt_i;
    end

    alu_share_arb_alu u_alu (
        .ctrl_i   (op_ctrl),
        .src1_i   (op_src1),
        .src2_i   (op_src2),
        .shamt_i  (op_shamt),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    // Next state: capture the ALU result on a grant, free the register when consumed.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        if (gnt0 || gnt1) begin
            state_d  = ST_FULL;
            owner_d  = gnt1;
            ptr_d    = gnt1;
            result_d = alu_result;
            zero_d   = (alu_result == '0);
            err_d    = alu_err;
        end else if ((state_q == ST_FULL) && owner_rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State register with synchronous reset; reset makes requester 0 win the first tie.
    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
        if (rst_i) begin
            state_q  <= ST_EMPTY;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign rsp0_valid_o = (state_q == ST_FULL) && !owner_q;
    assign rsp1_valid_o = (state_q == ST_FULL) && owner_q;
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: a round-robin and a fixed-priority instance share
// stimulus; a transaction-level model predicts both every cycle.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  v;
    logic [1:0]  rsp_rdy;
    logic [31:0] src1 [2];
    logic [31:0] src2 [2];
    logic [3:0]  ctrl [2];
    logic [4:0]  shamt [2];

    // Index 0 = round-robin instance, 1 = fixed-priority instance.
    logic [1:0]  rdy_o [2];
    logic [1:0]  rvld_o [2];
    logic [31:0] res_o [2];
    logic        zero_o [2];
    logic        err_o [2];

    int errors = 0;
    int checks = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    alu_share_arb #(.RR_EN(1)) dut_rr (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v[0]), .req1_valid_i(v[1]),
        .req0_ready_o(rdy_o[0][0]), .req1_ready_o(rdy_o[0][1]),
        .req0_src1_i(src1[0]), .req0_src2_i(src2[0]),
        .req1_src1_i(src1[1]), .req1_src2_i(src2[1]),
        .req0_ctrl_i(ctrl[0]), .req1_ctrl_i(ctrl[1]),
        .req0_shamt_i(shamt[0]), .req1_shamt_i(shamt[1]),
        .rsp0_valid_o(rvld_o[0][0]), .rsp1_valid_o(rvld_o[0][1]),
        .rsp0_ready_i(rsp_rdy[0]), .rsp1_ready_i(rsp_rdy[1]),
        .rsp_result_o(res_o[0]), .rsp_zero_o(zero_o[0]), .rsp_err_o(err_o[0])
    );

    alu_share_arb #(.RR_EN(0)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(v[0]), .req1_valid_i(v[1]),
        .req0_ready_o(rdy_o[1][0]), .req1_ready_o(rdy_o[1][1]),
        .req0_src1_i(src1[0]), .req0_src2_i(src2[0]),
        .req1_src1_i(src1[1]), .req1_src2_i(src2[1]),
        .req0_ctrl_i(ctrl[0]), .req1_ctrl_i(ctrl[1]),
        .req0_shamt_i(shamt[0]), .req1_shamt_i(shamt[1]),
        .rsp0_valid_o(rvld_o[1][0]), .rsp1_valid_o(rvld_o[1][1]),
        .rsp0_ready_i(rsp_rdy[0]), .rsp1_ready_i(rsp_rdy[1]),
        .rsp_result_o(res_o[1]), .rsp_zero_o(zero_o[1]), .rsp_err_o(err_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Held response per instance: present?, whose, value, error flag; plus last winner.
    logic        m_full [2];
    int          m_owner [2];
    logic [31:0] m_res [2];
    logic        m_err [2];
    int          m_last [2];

    function automatic logic [32:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [4:0] sh);
        case (op)
            4'd0:  return {1'b0, a & b};
            4'd1:  return {1'b0, a | b};
            4'd2:  return {1'b0, a + b};
            4'd3:  return {1'b0, a - b};
            4'd4:  return {1'b0, 32'(($signed(a) < $signed(b)) ? 1 : 0)};
            4'd5:  return {1'b0, 32'((a < b) ? 1 : 0)};
            4'd6:  return {1'b0, a - b};
            4'd7:  return {1'b0, b << sh};
            4'd8:  return {1'b0, b << a[4:0]};
            4'd9:  return {1'b0, b[15:0], 16'h0000};
            4'd10: return {1'b0, a | {16'h0000, b[15:0]}};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Which requester the instance must accept right now (-1 = none).
    function automatic int exp_grant(input int m);
        if (rst) return -1;
        if (m_full[m] && !rsp_rdy[m_owner[m]]) return -1;
        if (v[0] && v[1]) begin
            if (m == 1) return 0;
            return (m_last[m] == 0) ? 1 : 0;
        end
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            int g;
            logic [32:0] r;
            g = exp_grant(m);
            if (rst) begin
                m_full[m] <= 1'b0;
                m_owner[m] <= 0;
                m_res[m]  <= 32'h0;
                m_err[m]  <= 1'b0;
                m_last[m] <= 1;
            end else if (g >= 0) begin
                r = model_alu(ctrl[g], src1[g], src2[g], shamt[g]);
                m_full[m]  <= 1'b1;
                m_owner[m] <= g;
                m_res[m]   <= r[31:0];
                m_err[m]   <= r[32];
                m_last[m]  <= g;
            end else if (m_full[m] && rsp_rdy[m_owner[m]]) begin
                m_full[m] <= 1'b0;
            end
        end
    end

    // Compare every output of both instances against the model on the falling edge.
    string tag [2] = '{"rr", "fp"};
    always @(negedge clk) begin
        if (check_en) begin
            for (int m = 0; m < 2; m++) begin
                int g;
                g = exp_grant(m);
                check({tag[m], ".req0_ready"}, 32'(rdy_o[m][0]), 32'(g == 0));
                check({tag[m], ".req1_ready"}, 32'(rdy_o[m][1]), 32'(g == 1));
                check({tag[m], ".rsp0_valid"}, 32'(rvld_o[m][0]), 32'(m_full[m] && m_owner[m] == 0));
                check({tag[m], ".rsp1_valid"}, 32'(rvld_o[m][1]), 32'(m_full[m] && m_owner[m] == 1));
                check({tag[m], ".result"}, res_o[m], m_res[m]);
                check({tag[m], ".zero"}, 32'(zero_o[m]), 32'(m_res[m] == 32'h0));
                check({tag[m], ".err"}, 32'(err_o[m]), 32'(m_err[m]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh);
        ctrl[k]  = op;
        src1[k]  = a;
        src2[k]  = b;
        shamt[k] = sh;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8] = '{
        '{4'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000},  // AND
        '{4'd1,  32'h000000F0, 32'h0000000F, 32'h000000FF},  // OR
        '{4'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},  // SLT  -1 < 1
        '{4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},  // SLTU big < 1 is false
        '{4'd6,  32'h00000007, 32'h00000007, 32'h00000000},  // BNE equal operands
        '{4'd8,  32'h00000002, 32'h00000002, 32'h00000008},  // SLLV 2 << 2
        '{4'd9,  32'h00000000, 32'h00001234, 32'h12340000},  // LUI
        '{4'd10, 32'hFFFF0000, 32'h0000ABCD, 32'hFFFFABCD}   // ORI
    };

    initial begin
        rst     = 1'b1;
        v       = 2'b11;
        rsp_rdy = 2'b11;
        for (int k = 0; k < 2; k++) set_req(k, 4'd0, 32'h0, 32'h0, 5'd0);

        // Reset state, with both requests pending to show readys forced low.
        step();
        check_en = 1'b1;
        step();
        @(negedge clk);
        check("reset.result", res_o[0], 32'h0);
        check("reset.zero", 32'(zero_o[0]), 32'd1);
        check("reset.rsp_valid", 32'(rvld_o[0]), 32'd0);
        check("reset.readys", 32'(rdy_o[0]), 32'd0);

        // Both valid every cycle: round-robin alternates 0,1,0,1; fixed priority starves req1.
        step();
        rst = 1'b0;
        set_req(0, 4'd2, 32'd5, 32'd7, 5'd0);
        set_req(1, 4'd3, 32'd3, 32'd3, 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr.alt.ready0", 32'(rdy_o[0][0]), 32'(i % 2 == 0));
            check("rr.alt.ready1", 32'(rdy_o[0][1]), 32'(i % 2 == 1));
            check("fp.starve.ready", 32'(rdy_o[1]), 32'd1);
            step();
        end
        v = 2'b00;
        @(negedge clk);
        check("rr.sub.rsp1_valid", 32'(rvld_o[0][1]), 32'd1);
        check("rr.sub.result", res_o[0], 32'h0);
        check("rr.sub.zero", 32'(zero_o[0]), 32'd1);
        check("fp.add.result", res_o[1], 32'd12);
        step();

        // Req0 alone: ADD 5+7 answered next cycle.
        v = 2'b01;
        @(negedge clk);
        check("add.ready0", 32'(rdy_o[0][0]), 32'd1);
        step();
        v = 2'b00;
        @(negedge clk);
        check("add.rsp0_valid", 32'(rvld_o[0][0]), 32'd1);
        check("add.result", res_o[0], 32'd12);
        check("add.zero", 32'(zero_o[0]), 32'd0);
        check("add.err", 32'(err_o[0]), 32'd0);
        step();

        // Operation table through requester 0.
        for (int i = 0; i < 8; i++) begin
            set_req(0, vecs[i].op, vecs[i].a, vecs[i].b, 5'd0);
            v = 2'b01;
            step();
            v = 2'b00;
            @(negedge clk);
            check($sformatf("op%0d.result", vecs[i].op), res_o[0], vecs[i].exp);
            step();
        end

        // Backpressure: held SLT result, then release lets req1 in the same cycle.
        set_req(0, 4'd4, 32'hFFFFFFFF, 32'd1, 5'd0);
        set_req(1, 4'd1, 32'h000000F0, 32'h0000000F, 5'd0);
        rsp_rdy = 2'b10;
        v = 2'b01;
        step();
        v = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.held.result", res_o[0], 32'd1);
            check("bp.held.readys", 32'(rdy_o[0]), 32'd0);
            check("bp.held.rsp0_valid", 32'(rvld_o[0][0]), 32'd1);
            step();
        end
        rsp_rdy = 2'b11;
        @(negedge clk);
        check("bp.release.ready1", 32'(rdy_o[0][1]), 32'd1);
        step();
        v = 2'b00;
        @(negedge clk);
        check("bp.req1.result", res_o[0], 32'h000000FF);
        check("bp.req1.rsp1_valid", 32'(rvld_o[0][1]), 32'd1);
        step();

        // Illegal ctrl followed back-to-back by SLL.
        set_req(1, 4'd13, 32'd5, 32'd6, 5'd0);
        v = 2'b10;
        step();
        set_req(1, 4'd7, 32'h0000DEAD, 32'd1, 5'd4);
        @(negedge clk);
        check("err.result", res_o[0], 32'h0);
        check("err.zero", 32'(zero_o[0]), 32'd1);
        check("err.err", 32'(err_o[0]), 32'd1);
        step();
        v = 2'b00;
        @(negedge clk);
        check("sll.result", res_o[0], 32'd16);
        check("sll.err", 32'(err_o[0]), 32'd0);
        step();

        // Reset while FULL discards the response; first tie afterwards goes to req0.
        set_req(0, 4'd2, 32'd1, 32'd1, 5'd0);
        rsp_rdy = 2'b00;
        v = 2'b01;
        step();
        v = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        check("rst.readys", 32'(rdy_o[0]), 32'd0);
        check("rst.pre.rsp0_valid", 32'(rvld_o[0][0]), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst.post.rsp_valid", 32'(rvld_o[0]), 32'd0);
        check("rst.post.result", res_o[0], 32'h0);
        check("rst.post.zero", 32'(zero_o[0]), 32'd1);
        check("rst.tie.ready0", 32'(rdy_o[0][0]), 32'd1);
        check("rst.tie.ready1", 32'(rdy_o[0][1]), 32'd0);
        step();
        v = 2'b00;
        rsp_rdy = 2'b11;
        @(negedge clk);
        check("rst.tie.result", res_o[0], 32'd2);
        step();
        step();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
